// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter with packet lock that merges NUM_REQ byte streams onto one
// valid/ready egress through a two-entry main/skid output buffer.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no packet open; winner searched from rr_ptr each cycle
// ST_LOCKED | packet open; only the owner may transfer until its last beat

module rr_stream_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int ID_W    = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]        req_last_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   output logic                      e_valid_o,
   output logic [DATA_W-1:0]         e_data_o,
   output logic                      e_last_o,
   output logic [ID_W-1:0]           e_id_o,
   input  logic                      e_ready_i,
   output logic                      busy_o
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
   logic [ID_W-1:0]   owner, owner_nxt;

   logic              found;
   logic [ID_W-1:0]   winner;
   logic [ID_W-1:0]   sel;
   logic              grant_on;
   logic              grant_valid;
   logic              in_ready;
   logic              accept;
   logic [DATA_W-1:0] in_data;
   logic              in_last;

   logic              m_valid, s_valid;
   logic [DATA_W-1:0] m_data, s_data;
   logic              m_last, s_last;
   logic [ID_W-1:0]   m_id, s_id;
   logic              drain;

   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
      if (v == ID_W'(NUM_REQ - 1)) begin
         return '0;
      end
      return v + ID_W'(1);
   endfunction

   // Lowest valid index at or above rr_ptr wins; otherwise the lowest valid overall.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid_i[i]) begin
            found  = 1'b1;
            winner = ID_W'(i);
         end
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid_i[i] && (ID_W'(i) >= rr_ptr)) begin
            winner = ID_W'(i);
         end
      end
   end

   // Reset also gates ready so nothing is offered while the block is held in reset.
   assign in_ready    = ~s_valid & ~reset;
   assign sel         = (state == ST_LOCKED) ? owner : winner;
   assign grant_on    = (state == ST_LOCKED) | found;
   assign grant_valid = (state == ST_LOCKED) ? req_valid_i[owner] : found;
   assign accept      = grant_valid & in_ready;
   assign in_data     = req_data_i[sel*DATA_W +: DATA_W];
   assign in_last     = req_last_i[sel];
   assign drain       = m_valid & e_ready_i;

   always_comb begin
      req_ready_o = '0;
      if (grant_on && in_ready) begin
         req_ready_o[sel] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         rr_ptr <= '0;
         owner  <= '0;
      end else begin
         state  <= state_nxt;
         rr_ptr <= rr_ptr_nxt;
         owner  <= owner_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      rr_ptr_nxt = rr_ptr;
      owner_nxt  = owner;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (in_last) begin
                  rr_ptr_nxt = wrap_inc(winner);
               end else begin
                  state_nxt = ST_LOCKED;
                  owner_nxt = winner;
               end
            end
         end
         ST_LOCKED: begin
            if (accept && in_last) begin
               state_nxt  = ST_IDLE;
               rr_ptr_nxt = wrap_inc(owner);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Accept is impossible while the skid slot is full, so the two branches never overlap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_last  <= 1'b0;
         m_id    <= '0;
         s_valid <= 1'b0;
         s_data  <= '0;
         s_last  <= 1'b0;
         s_id    <= '0;
      end else if (s_valid) begin
         if (drain) begin
            m_data  <= s_data;
            m_last  <= s_last;
            m_id    <= s_id;
            s_valid <= 1'b0;
         end
      end else if (accept) begin
         if (!m_valid || drain) begin
            m_valid <= 1'b1;
            m_data  <= in_data;
            m_last  <= in_last;
            m_id    <= sel;
         end else begin
            s_valid <= 1'b1;
            s_data  <= in_data;
            s_last  <= in_last;
            s_id    <= sel;
         end
      end else if (drain) begin
         m_valid <= 1'b0;
      end
   end

   assign e_valid_o = m_valid;
   assign e_data_o  = m_data;
   assign e_last_o  = m_last;
   assign e_id_o    = m_id;
   assign busy_o    = (state == ST_LOCKED);

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Scoreboard bench for rr_stream_arbiter: a queue-based arbitration model predicts
// every egress beat and ready pattern; a monitor compares what the DUT presents.

module tb_rr_stream_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]  req_last;
   logic [N-1:0]  req_ready;
   logic          e_valid;
   logic [DW-1:0] e_data;
   logic          e_last;
   logic [IW-1:0] e_id;
   logic          e_ready;
   logic          busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rr_stream_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
      .req_ready_o(req_ready),
      .e_valid_o(e_valid), .e_data_o(e_data), .e_last_o(e_last), .e_id_o(e_id),
      .e_ready_i(e_ready), .busy_o(busy)
   );

   typedef struct packed { logic [7:0] data; logic last; logic [1:0] id; } beat_t;
   typedef struct packed { logic [7:0] data; logic last; } src_t;

   beat_t exp_q[$];
   src_t  script [N][$];
   logic [N-1:0] hold;

   // reference model state
   bit m_locked;
   int m_owner, m_ptr, m_cnt;
   int acc_id;
   int cyc;
   int acc_cyc[$];
   int log_id[$];
   int log_cyc[$];
   int log_data[$];
   int exp_ids[$];
   int exp_data[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int pick();
      if (m_locked) return req_valid[m_owner] ? m_owner : -1;
      for (int k = 0; k < N; k++) begin
         if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      logic [N-1:0] r;
      int g;
      r = '0;
      if (reset || m_cnt >= 2) return r;
      g = pick();
      if (m_locked) r[m_owner] = 1'b1;
      else if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   // model: arbitration and buffer occupancy, pushes expected beats
   initial begin
      m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; acc_id = -1; cyc = 0;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; acc_id = -1;
            exp_q.delete();
         end else begin
            int g;
            bit drn;
            cyc++;
            g = pick();
            drn = (m_cnt > 0) && e_ready;
            acc_id = -1;
            if (g >= 0 && m_cnt < 2) begin
               acc_id = g;
               exp_q.push_back(beat_t'({req_data[g*DW +: DW], req_last[g], 2'(g)}));
               acc_cyc.push_back(cyc);
               m_cnt++;
               if (req_last[g]) begin
                  m_locked = 0;
                  m_ptr = (g + 1) % N;
               end else if (!m_locked) begin
                  m_locked = 1;
                  m_owner = g;
               end
            end
            if (drn) m_cnt--;
         end
      end
   end

   // monitor: compares presented outputs, pops on handshake
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            check("e_valid", e_valid, m_cnt > 0);
            check("req_ready", req_ready, exp_ready());
            check("busy", busy, m_locked);
            if (e_valid) begin
               if (exp_q.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL egress_unexpected: got beat %0h, scoreboard empty", e_data);
               end else begin
                  check("e_data", e_data, exp_q[0].data);
                  check("e_last", e_last, exp_q[0].last);
                  check("e_id", e_id, exp_q[0].id);
                  if (e_ready) begin
                     log_id.push_back(int'(e_id));
                     log_data.push_back(int'(e_data));
                     log_cyc.push_back(cyc);
                     void'(exp_q.pop_front());
                  end
               end
            end
         end
      end
   end

   task automatic step_producers();
      for (int i = 0; i < N; i++) begin
         if (acc_id == i && script[i].size() > 0) void'(script[i].pop_front());
         if (!(req_valid[i] && acc_id != i)) begin
            if (script[i].size() > 0 && !hold[i]) begin
               req_valid[i] = 1'b1;
               req_data[i*DW +: DW] = script[i][0].data;
               req_last[i] = script[i][0].last;
            end else begin
               req_valid[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      step_producers();
   endtask

   task automatic clear_logs();
      log_id.delete(); log_data.delete(); log_cyc.delete(); acc_cyc.delete();
   endtask

   task automatic check_log(input string name);
      check({name, "_count"}, log_id.size(), exp_ids.size());
      for (int k = 0; k < exp_ids.size() && k < log_id.size(); k++) begin
         check({name, "_id"}, log_id[k], exp_ids[k]);
         if (k < exp_data.size()) check({name, "_data"}, log_data[k], exp_data[k]);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_e_valid"}, e_valid, 0);
      check({name, "_e_data"}, e_data, 0);
      check({name, "_e_last"}, e_last, 0);
      check({name, "_e_id"}, e_id, 0);
      check({name, "_busy"}, busy, 0);
      check({name, "_req_ready"}, req_ready, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, low, gap, n2, r1_high, left;
      bit pat[$];
      reset = 1'b0; req_valid = '0; req_data = '0; req_last = '0; e_ready = 1'b0; hold = '0;
      #1 reset = 1'b1;
      req_valid = '1;
      repeat (2) @(posedge clk);
      #2;
      check_reset_outputs("reset");
      req_valid = '0;
      @(negedge clk) reset = 1'b0;

      // single-beat packets from all four requesters
      clear_logs();
      for (int i = 0; i < N; i++) script[i].push_back(src_t'({8'((i + 1) * 16), 1'b1}));
      e_ready = 1'b1;
      repeat (10) tick();
      exp_ids = '{0, 1, 2, 3}; exp_data = '{8'h10, 8'h20, 8'h30, 8'h40};
      check_log("t1");
      if (log_cyc.size() == 4 && acc_cyc.size() >= 1) begin
         check("t1_latency", log_cyc[0], acc_cyc[0]);
         for (int k = 1; k < 4; k++) check("t1_back_to_back", log_cyc[k] - log_cyc[k-1], 1);
      end

      // pointer to 1, then locked 3-beat packet from req1 against req0/req2
      script[0].push_back(src_t'({8'h01, 1'b1}));
      repeat (4) tick();
      clear_logs();
      script[1].push_back(src_t'({8'hA1, 1'b0}));
      script[1].push_back(src_t'({8'hA2, 1'b0}));
      script[1].push_back(src_t'({8'hA3, 1'b1}));
      script[0].push_back(src_t'({8'h0B, 1'b1}));
      script[2].push_back(src_t'({8'h2B, 1'b1}));
      repeat (12) tick();
      exp_ids = '{1, 1, 1, 2, 0}; exp_data = '{8'hA1, 8'hA2, 8'hA3, 8'h2B, 8'h0B};
      check_log("t2");

      // req3 stream under egress stalls
      clear_logs();
      for (int k = 0; k < 4; k++) script[3].push_back(src_t'({8'(8'h31 + k), k == 3}));
      pat = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
      low = 0;
      for (int k = 0; k < pat.size(); k++) begin
         e_ready = pat[k];
         tick();
         #2;
         if (req_valid[3] && !req_ready[3]) low++;
      end
      check("t3_ready_low_cycles", low, 2);
      exp_ids = '{3, 3, 3, 3}; exp_data = '{8'h31, 8'h32, 8'h33, 8'h34};
      check_log("t3");

      // wrap from req3 back to req0
      clear_logs();
      e_ready = 1'b1;
      script[3].push_back(src_t'({8'h3F, 1'b1}));
      repeat (2) tick();
      script[0].push_back(src_t'({8'h0F, 1'b1}));
      script[1].push_back(src_t'({8'h1F, 1'b1}));
      repeat (6) tick();
      exp_ids = '{3, 0, 1}; exp_data = '{8'h3F, 8'h0F, 8'h1F};
      check_log("t4");

      // reset in the middle of a packet
      clear_logs();
      e_ready = 1'b0;
      script[1].push_back(src_t'({8'hB1, 1'b0}));
      script[1].push_back(src_t'({8'hB2, 1'b0}));
      script[1].push_back(src_t'({8'hB3, 1'b1}));
      n = 0;
      for (int k = 0; k < 20 && n < 2; k++) begin
         tick();
         if (acc_id == 1) n++;
      end
      check("t5_two_beats_accepted", n, 2);
      #2 reset = 1'b1;
      #1;
      check_reset_outputs("t5_reset");
      req_valid = '0;
      for (int i = 0; i < N; i++) script[i].delete();
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      clear_logs();
      e_ready = 1'b1;
      script[1].push_back(src_t'({8'h15, 1'b1}));
      script[0].push_back(src_t'({8'h05, 1'b1}));
      repeat (6) tick();
      exp_ids = '{0, 1}; exp_data = '{8'h05, 8'h15};
      check_log("t5");

      // owner req2 drops valid mid-packet while req1 waits
      clear_logs();
      for (int k = 0; k < 4; k++) script[2].push_back(src_t'({8'(8'hC1 + k), k == 3}));
      script[1].push_back(src_t'({8'h1E, 1'b1}));
      n2 = 0; gap = 0; r1_high = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk);
         #1;
         if (acc_id == 2) n2++;
         hold[2] = (n2 == 1 && gap < 3);
         if (hold[2]) gap++;
         step_producers();
         #2;
         if (hold[2] && req_ready[1]) r1_high++;
      end
      hold = '0;
      check("t6_gap_cycles", gap, 3);
      check("t6_req1_ready_during_gap", r1_high, 0);
      exp_ids = '{2, 2, 2, 2, 1}; exp_data = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h1E};
      check_log("t6");

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         e_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (script[i].size() == 0 && $urandom_range(0, 9) == 0) begin
               left = $urandom_range(1, 4);
               for (int b = 0; b < left; b++)
                  script[i].push_back(src_t'({8'($urandom), b == left - 1}));
            end
            hold[i] = ($urandom_range(0, 7) == 0);
         end
         tick();
      end
      hold = '0;
      e_ready = 1'b1;
      repeat (80) tick();
      left = 0;
      for (int i = 0; i < N; i++) left += script[i].size();
      check("rand_sources_drained", left, 0);
      check("rand_scoreboard_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_stream_arbiter.md
Name: rr_stream_arbiter

Overview:
- Shares one valid/ready byte stream between NUM_REQ upstream requesters using round-robin arbitration with packet lock.
- A granted requester keeps the channel until its last beat is accepted.
- The output side is a 2-entry skid buffer, so upstream ready never depends combinationally on e_ready_i and full throughput is kept under downstream stalls.
- Sits between the per-source producers and the single egress consumer.

Parameters:
- NUM_REQ, 4, number of requesters; 2..8.
- DATA_W, 8, beat width in bits.
- ID_W, 2, width of requester index; must equal max(1, clog2(NUM_REQ)).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- req_valid_i  in  NUM_REQ  per-requester valid.
- req_data_i  in  NUM_REQ*DATA_W  per-requester data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last_i  in  NUM_REQ  per-requester end-of-packet flag.
- req_ready_o  out  NUM_REQ  per-requester ready; at most one bit high in any cycle.
- e_valid_o  out  1  egress valid.
- e_data_o  out  DATA_W  egress data.
- e_last_o  out  1  egress end-of-packet.
- e_id_o  out  ID_W  index of the requester that produced the egress beat.
- e_ready_i  in  1  egress ready.
- busy_o  out  1  high while in LOCKED.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, rr_ptr=0, owner=0.
  - Main and skid slots invalid; e_valid_o=0, e_data_o=0, e_last_o=0, e_id_o=0, busy_o=0, req_ready_o=0.
- Handshake:
  - A transfer occurs on a rising edge when valid and ready are both high.
  - Producers must hold valid, data and last stable until accepted.
  - e_valid_o, once high, stays high with stable e_data_o/e_last_o/e_id_o until e_ready_i.
- Buffer:
  - in_ready = ~skid_valid (registered).
  - An accepted beat appears on e_valid_o the next cycle (latency 1) if the main slot is empty or draining that cycle; otherwise it lands in the skid slot.
  - On e_ready_i with skid valid, the skid slot moves to the main slot.
  - Order is strictly preserved. Sustained 1 beat/cycle when e_ready_i=1.
- IDLE:
  - winner = first i with req_valid_i[i]=1, searching i = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready_o[winner] = in_ready; all other ready bits are 0. No valid inputs means no ready.
  - On an accepted beat with last=1: stay IDLE, rr_ptr = (winner+1) mod NUM_REQ.
  - On an accepted beat with last=0: go to LOCKED, owner = winner. rr_ptr is unchanged.
  - If the winner is not accepted because in_ready=0, nothing changes; arbitration is re-evaluated next cycle.
- LOCKED:
  - req_ready_o[owner] = in_ready; all others are 0, regardless of their valid.
  - An accepted beat with last=1 goes to IDLE with rr_ptr = (owner+1) mod NUM_REQ.
  - The owner dropping valid mid-packet keeps the lock; there is no timeout.
- e_id_o carries the requester index captured with each beat; it travels through the skid slot with the data.
- Wrap-around: pointer arithmetic is modulo NUM_REQ, so index NUM_REQ-1 followed by +1 gives 0.
- Simultaneous events:
  - Accept into the buffer and drain from the buffer in the same cycle are both honoured.
  - Last-beat acceptance and a new request in the same cycle: the new grant takes effect next cycle (one idle arbitration cycle is allowed only in that case). The back-to-back single-beat packets required below are produced in IDLE, not through this path.
- Reset mid-packet drops any lock and all buffered beats; no partial packet is emitted after reset.

Test Plan:
- Reset, then all four requesters send single-beat packets (data 0x10,0x20,0x30,0x40, last=1) with e_ready_i=1 -> egress order id 0,1,2,3 on consecutive cycles; first beat one cycle after first accept; rr_ptr back at 0.
- Req1 sends a 3-beat packet 0xA1,0xA2,0xA3 while req0 and req2 stay valid -> egress A1,A2,A3 with id=1 contiguously, busy_o=1 for the packet, then req2 is granted next (not req0).
- Stream from req3 with e_ready_i toggling 1,0,0,1,1 -> no beat lost or duplicated; req_ready_o[3] drops the cycle after the skid slot fills; e_data_o stays stable while stalled.
- Req3 single-beat, then req0 valid -> rr wraps: req0 granted next and e_id_o=0.
- Assert reset in the middle of the 3-beat packet after beat 2 is accepted -> all outputs 0 immediately; after release an arbitration starting at rr_ptr=0 grants req0 if valid.
- Owner req2 deasserts valid for 3 cycles mid-packet while req1 is valid -> req_ready_o[1] stays 0 throughout; the packet resumes and completes before req1 is granted.
